oled_dot_matrix_disp: RTL and testbench



---
 rtl/oled_pkg.sv | 63 ++++++
 rtl/oled_dot_matrix_disp_font_rom.sv | 19 +
 rtl/oled_dot_matrix_disp.sv | 140 ++++++++++++++
 tb/tb_oled_dot_matrix_disp.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types, protocol constants and font table for the OLED character-draw controller.
package oled_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    LOAD,
    ISSUE,
    WAIT
  } state_e;

  localparam logic [7:0] CMD_REG    = 8'h00;
  localparam logic [7:0] DATA_REG   = 8'h40;
  localparam logic [7:0] SET_PAGE   = 8'hB0;
  localparam logic [7:0] SET_COL_LO = 8'h00;
  localparam logic [7:0] SET_COL_HI = 8'h10;
  localparam logic [7:0] FONT_FIRST = 8'h20;
  localparam logic [7:0] FONT_LAST  = 8'h7F;

  localparam int unsigned FONT_GLYPHS = 96;
  localparam int unsigned NUM_CMD     = 3;

  // 5x7 glyphs, one 40-bit word per character; first column in the top byte.
  // Columns 5..7 of every 8-column cell are blank spacing.
  localparam logic [39:0] FONT_5X7 [FONT_GLYPHS] = '{
    40'h0000000000, 40'h00005F0000, 40'h0007000700, 40'h147F147F14, 40'h242A7F2A12, 40'h2313086462,
    40'h3649552250, 40'h0005030000, 40'h001C224100, 40'h0041221C00, 40'h082A1C2A08, 40'h08083E0808,
    40'h0050300000, 40'h0808080808, 40'h0060600000, 40'h2010080402, 40'h3E5149453E, 40'h00427F4000,
    40'h4261514946, 40'h2141454B31, 40'h1814127F10, 40'h2745454539, 40'h3C4A494930, 40'h0171090503,
    40'h3649494936, 40'h064949291E, 40'h0036360000, 40'h0056360000, 40'h0008142241, 40'h1414141414,
    40'h4122140800, 40'h0201510906, 40'h324979413E, 40'h7E1111117E, 40'h7F49494936, 40'h3E41414122,
    40'h7F4141221C, 40'h7F49494941, 40'h7F09090101, 40'h3E41415132, 40'h7F0808087F, 40'h00417F4100,
    40'h2040413F01, 40'h7F08142241, 40'h7F40404040, 40'h7F0204027F, 40'h7F0408107F, 40'h3E4141413E,
    40'h7F09090906, 40'h3E4151215E, 40'h7F09192946, 40'h4649494931, 40'h01017F0101, 40'h3F4040403F,
    40'h1F2040201F, 40'h7F2018207F, 40'h6314081463, 40'h0304780403, 40'h6151494543, 40'h00007F4141,
    40'h0204081020, 40'h41417F0000, 40'h0402010204, 40'h4040404040, 40'h0001020400, 40'h2054545478,
    40'h7F48444438, 40'h3844444420, 40'h384444487F, 40'h3854545418, 40'h087E090102, 40'h081454543C,
    40'h7F08040478, 40'h00447D4000, 40'h2040443D00, 40'h007F102844, 40'h00417F4000, 40'h7C04180478,
    40'h7C08040478, 40'h3844444438, 40'h7C14141408, 40'h081414187C, 40'h7C08040408, 40'h4854545420,
    40'h043F444020, 40'h3C4040207C, 40'h1C2040201C, 40'h3C4030403C, 40'h4428102844, 40'h0C5050503C,
    40'h4464544C44, 40'h0008364100, 40'h00007F0000, 40'h0041360800, 40'h08082A1C08, 40'h081C2A0808
  };

  // Table index for a character code; out-of-range codes fall back to the blank space glyph.
  function automatic logic [6:0] font_index(input logic [7:0] code);
    font_index = '0;
    if (code >= FONT_FIRST && code <= FONT_LAST) begin
      font_index = 7'(code - FONT_FIRST);
    end
  endfunction

  // One column byte of a glyph (bit0 = top pixel row).
  function automatic logic [7:0] font_byte(input logic [6:0] idx, input logic [2:0] col);
    logic [39:0] g;
    font_byte = '0;
    g         = '0;
    if (idx < 7'(FONT_GLYPHS) && col < 3'd5) begin
      g         = FONT_5X7[idx];
      font_byte = g[8 * (4 - int'(col)) +: 8];
    end
  endfunction

endpackage

// File: rtl/oled_dot_matrix_disp_font_rom.sv
// Synchronous 96x8 glyph ROM, address {glyph index, column}, one-cycle read latency.
module oled_font_rom
  import oled_pkg::*;
(
  input  logic       clk,
  input  logic [9:0] addr_i,
  output logic [7:0] data_o
);

  logic [7:0] data_q;

  // Registered read so the table maps onto block ROM.
  always_ff @(posedge clk) begin
    data_q <= font_byte(addr_i[9:3], addr_i[2:0]);
  end

  assign data_o = data_q;

endmodule

// File: rtl/oled_dot_matrix_disp.sv
// Character-draw controller: collects {code, column, page}, then issues the
// page/column setup commands and eight glyph column writes to an I2C master.
module oled_dot_matrix_disp
  import oled_pkg::*;
#(
  parameter logic [7:0]  CMD_REG  = 8'h00,
  parameter logic [7:0]  DATA_REG = 8'h40,
  parameter int unsigned GLYPH_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       rdy,
  input  logic       wen,
  input  logic [7:0] din,
  output logic       done,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       i2c_wen,
  input  logic       i2c_done
);

  localparam logic [3:0] LAST_TX = 4'(NUM_CMD + GLYPH_W - 1);

  state_e     state_q;
  logic [1:0] cnt_q;
  logic [7:0] code_q;
  logic [6:0] col_q;
  logic [2:0] page_q;
  logic [3:0] tx_q;
  logic       rdy_q;
  logic       done_q;
  logic       wen_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;

  logic [2:0] glyph_col;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] tx_addr_d;
  logic [7:0] tx_data_d;

  // Glyph column follows the transaction index; it is stable from LOAD onward,
  // so the ROM output is valid by ISSUE.
  always_comb begin
    glyph_col = 3'(tx_q - 4'(NUM_CMD));
    rom_addr  = {font_index(code_q), glyph_col};
  end

  oled_font_rom u_font_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  // Control byte and payload for the current transaction.
  always_comb begin
    tx_addr_d = CMD_REG;
    tx_data_d = '0;
    case (tx_q)
      4'd0:    tx_data_d = SET_PAGE   | {5'b0, page_q};
      4'd1:    tx_data_d = SET_COL_LO | {4'h0, col_q[3:0]};
      4'd2:    tx_data_d = SET_COL_HI | {5'b0, col_q[6:4]};
      default: begin
        tx_addr_d = DATA_REG;
        tx_data_d = rom_data;
      end
    endcase
  end

  // Main sequencer: request collection, per-write handshake and completion pulse.
  // The bus bytes and strobe are registered on leaving ISSUE, so i2c_wen is high
  // in the first WAIT cycle; i2c_done is not accepted while the strobe is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      col_q   <= '0;
      page_q  <= '0;
      tx_q    <= '0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      wen_q  <= 1'b0;
      case (state_q)
        IDLE, COLLECT: begin
          rdy_q <= 1'b1;
          if (rdy_q && wen) begin
            case (cnt_q)
              2'd0:    code_q <= din;
              2'd1:    col_q  <= din[6:0];
              default: page_q <= din[2:0];
            endcase
            if (cnt_q == 2'd2) begin
              cnt_q   <= '0;
              tx_q    <= '0;
              rdy_q   <= 1'b0;
              state_q <= LOAD;
            end else begin
              cnt_q   <= cnt_q + 2'd1;
              state_q <= COLLECT;
            end
          end
        end
        LOAD: begin
          state_q <= ISSUE;
        end
        ISSUE: begin
          addr_q  <= tx_addr_d;
          data_q  <= tx_data_d;
          wen_q   <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (i2c_done && !wen_q) begin
            if (tx_q == LAST_TX) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              tx_q    <= tx_q + 4'd1;
              state_q <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdy      = rdy_q;
  assign done     = done_q;
  assign i2c_wen  = wen_q;
  assign reg_addr = addr_q;
  assign reg_data = data_q;

endmodule

// File: tb/tb_oled_dot_matrix_disp.sv
// Self-checking bench for oled_dot_matrix_disp with a responding I2C master model.
module tb_oled_dot_matrix_disp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wen = 1'b0;
  logic [7:0] din = '0;
  logic       resp_done = 1'b0;
  logic       idle_poke = 1'b0;
  logic       i2c_done;
  logic       rdy, done, i2c_wen;
  logic [7:0] reg_addr, reg_data;

  assign i2c_done = resp_done | idle_poke;

  always #5 clk = ~clk;

  oled_dot_matrix_disp #(
    .CMD_REG  (8'h00),
    .DATA_REG (8'h40),
    .GLYPH_W  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .wen      (wen),
    .din      (din),
    .done     (done),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .i2c_wen  (i2c_wen),
    .i2c_done (i2c_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] glyph_model(input logic [7:0] code, input int c);
    logic [39:0] g;
    int idx;
    if (code < 8'h20 || code > 8'h7F || c > 4) return 8'h00;
    idx = int'(code) - 32;
    g = oled_pkg::FONT_5X7[idx];
    return 8'((g >> (8 * (4 - c))) & 40'hFF);
  endfunction

  logic [15:0] exp_q[$];
  int exp_done = 0;

  task automatic push_model(input logic [7:0] code, input logic [7:0] cb, input logic [7:0] pb);
    int page, col;
    page = int'(pb) % 8;
    col  = int'(cb) % 128;
    exp_q.push_back({8'h00, 8'(176 + page)});
    exp_q.push_back({8'h00, 8'(col % 16)});
    exp_q.push_back({8'h00, 8'(16 + col / 16)});
    for (int i = 0; i < 8; i++) exp_q.push_back({8'h40, glyph_model(code, i)});
    exp_done++;
  endtask

  // ---------------- I2C master responder ----------------
  int resp_delay = 2;
  int pend_cnt = 0;
  bit pend = 0;

  always @(posedge clk) begin
    #1;
    resp_done = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          resp_done = 1'b1;
          pend = 0;
        end
      end
      if (i2c_wen === 1'b1) begin
        pend = 1;
        pend_cnt = resp_delay;
      end
    end
  end

  // ---------------- compare process ----------------
  logic [7:0] hold_a, hold_d;
  bit hold_v = 0;
  int n_wen = 0;

  always @(negedge clk) begin : cmp
    logic [15:0] e;
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      if (i2c_wen === 1'b1) begin
        chk("wen_not_early", 32'(hold_v), 0);
        chk("wen_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("tx_reg_addr", reg_addr, e[15:8]);
          chk("tx_reg_data", reg_data, e[7:0]);
        end
        hold_a = reg_addr;
        hold_d = reg_data;
        hold_v = 1;
        n_wen++;
      end else if (hold_v) begin
        chk("hold_reg_addr", reg_addr, hold_a);
        chk("hold_reg_data", reg_data, hold_d);
        if (i2c_done) hold_v = 0;
      end
      if (done !== 1'b0) begin
        chk("done_expected", 32'(exp_done > 0), 1);
        chk("done_after_all_tx", exp_q.size(), 0);
        chk("done_tx_closed", 32'(hold_v), 0);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    wen = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    chk("rdy_collect", rdy, 1);
    wen = 1'b1;
    din = b;
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"}, rdy, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_i2c_wen"}, i2c_wen, 0);
    chk({tag, "_reg_addr"}, reg_addr, 0);
    chk({tag, "_reg_data"}, reg_data, 0);
  endtask

  task automatic draw(input logic [7:0] code, input logic [7:0] cb, input logic [7:0] pb,
                      input int gap, input int delay, input bit noisy);
    int start_wen;
    bit got_done;
    resp_delay = delay;
    push_model(code, cb, pb);
    start_wen = n_wen;
    send_byte(code, gap);
    send_byte(cb, gap);
    send_byte(pb, gap);
    chk("rdy_busy", rdy, 0);
    got_done = 0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      if (noisy) begin
        wen = 1'($urandom_range(0, 1));
        din = 8'($urandom);
      end
      @(posedge clk);
      #1;
      if (done === 1'b1) got_done = 1;
      else chk("rdy_busy_hold", rdy, 0);
    end
    wen = 1'b0;
    chk("done_seen", 32'(got_done), 1);
    chk("rdy_in_done_cycle", rdy, 0);
    @(posedge clk);
    #1;
    chk("rdy_after_done", rdy, 1);
    chk("done_one_cycle", done, 0);
    chk("wen_count", n_wen - start_wen, 11);
    chk("model_drained", exp_q.size(), 0);
  endtask

  initial begin : main
    int start_wen;
    bit reached;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("after_reset");

    // Pin the model with hand-derived values
    chk("pin_glyph5_c0", glyph_model(8'h35, 0), 8'h27);
    chk("pin_glyph5_c4", glyph_model(8'h35, 4), 8'h39);
    chk("pin_glyph5_c5", glyph_model(8'h35, 5), 8'h00);
    chk("pin_glyphA_c1", glyph_model(8'h41, 1), 8'h11);
    chk("pin_space_c2", glyph_model(8'h20, 2), 8'h00);
    push_model(8'h35, 8'hAB, 8'hCD);
    chk("pin_t0", exp_q[0], 16'h00B5);
    chk("pin_t1", exp_q[1], 16'h000B);
    chk("pin_t2", exp_q[2], 16'h0012);
    chk("pin_t3", exp_q[3], 16'h4027);
    chk("pin_t10", exp_q[10], 16'h4000);
    exp_q.delete();
    exp_done = 0;

    // i2c_done while idle must be ignored
    for (int i = 0; i < 4; i++) begin
      idle_poke = 1'(i % 2 == 0);
      @(posedge clk);
      #1;
      chk("idle_no_wen", i2c_wen, 0);
      chk("idle_no_done", done, 0);
      chk("idle_rdy", rdy, 1);
    end
    idle_poke = 1'b0;

    // Directed draws
    draw(8'h35, 8'hAB, 8'hCD, 0, 2, 0);
    draw(8'h20, 8'h00, 8'h00, 0, 2, 0);
    draw(8'h05, 8'h7F, 8'h07, 0, 3, 1);
    draw(8'h41, 8'h12, 8'h03, 3, 20, 0);
    draw(8'h7F, 8'hFF, 8'hF8, 1, 1, 0);

    // Reset during the T5 wait aborts the draw
    resp_delay = 20;
    push_model(8'h48, 8'h10, 8'h02);
    start_wen = n_wen;
    send_byte(8'h48, 0);
    send_byte(8'h10, 0);
    send_byte(8'h02, 0);
    reached = 0;
    for (int c = 0; c < 2000 && !reached; c++) begin
      @(posedge clk);
      #1;
      if (n_wen - start_wen >= 6) reached = 1;
    end
    chk("t5_reached", 32'(reached), 1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    exp_q.delete();
    exp_done = 0;
    hold_v = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", done, 0);
      chk("abort_no_wen", i2c_wen, 0);
    end

    // A partially collected request is discarded by reset
    send_byte(8'h7A, 0);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    draw(8'h4F, 8'h40, 8'h05, 1, 2, 0);

    // Randomized draws
    for (int n = 0; n < 10; n++) begin
      draw(8'($urandom), 8'($urandom), 8'($urandom),
           int'($urandom_range(0, 2)), int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("no_pending_done", exp_done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
